// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: deframer states, frame geometry and the
// odd-parity check used on every received byte.
package ps2_pkg;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_rx_state_t;

   // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
   function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                              input logic                     par);
      return ^{par, data};
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead FIFO for received scancodes: the head entry is always visible and a
// push is still accepted when full if a pop frees a slot on the same edge.
module ps2_byte_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: line synchroniser, clock glitch filter, 11-bit
// deframer with parity/stop/timeout checks, and a scancode FIFO toward the decoder.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter  int SYNC_STAGES    = 2,
   parameter  int FILTER_LEN     = 8,
   parameter  int TIMEOUT_CYCLES = 100000,
   parameter  int FIFO_DEPTH     = 8,
   localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [CNT_W-1:0] fifo_count,
   output logic             busy,
   output logic             err_parity,
   output logic             err_frame,
   output logic             err_timeout,
   output logic             err_overrun
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0]   clk_sync;
   logic [SYNC_STAGES-1:0]   dat_sync;
   logic                     clk_s;
   logic                     dat_s;
   logic [FILTER_LEN-1:0]    filt_hist;
   logic [FILTER_LEN-1:0]    hist_next;
   logic                     filt_clk;
   logic                     filt_clk_d;
   logic                     strobe;

   ps2_rx_state_t            state;
   ps2_rx_state_t            state_nxt;
   logic [2:0]               bit_idx;
   logic [TMO_W-1:0]         tmo_cnt;
   logic                     tmo_hit;
   logic [PS2_DATA_BITS-1:0] shreg;
   logic                     par_bit;
   logic                     stop_strobe;
   logic                     frm_bad;
   logic                     par_bad;
   logic                     frm_good;

   logic [7:0]               byte_p1;
   logic                     push_p1;
   logic                     par_err_p1;
   logic                     frm_err_p1;
   logic                     tmo_err_p1;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [7:0]               fifo_head;

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];

   // ---- stage 0: synchronise both lines, idle-high after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   generate
      if (FILTER_LEN == 1) begin : g_hist1
         assign hist_next = clk_s;
      end else begin : g_histn
         assign hist_next = {filt_hist[FILTER_LEN-2:0], clk_s};
      end
   endgenerate

   // ---- stage 1: filtered clock changes only after FILTER_LEN agreeing samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_hist  <= '1;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
      end else begin
         filt_hist <= hist_next;
         if (filt_hist == '0)      filt_clk <= 1'b0;
         else if (filt_hist == '1) filt_clk <= 1'b1;
         filt_clk_d <= filt_clk;
      end
   end

   assign strobe  = filt_clk_d && !filt_clk;
   assign tmo_hit = (state != IDLE) && !strobe && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // ---- stage 2: deframer state register and control counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_idx <= '0;
         tmo_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (strobe || state == IDLE || tmo_hit) tmo_cnt <= '0;
         else                                    tmo_cnt <= tmo_cnt + 1'b1;
         if (strobe && state == IDLE)      bit_idx <= '0;
         else if (strobe && state == DATA) bit_idx <= bit_idx + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (tmo_hit) begin
         state_nxt = IDLE;
      end else if (strobe) begin
         case (state)
            IDLE:    if (!dat_s) state_nxt = DATA;
            DATA:    if (bit_idx == 3'(PS2_DATA_BITS - 1)) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // A bad stop bit masks any parity verdict on the same frame
   always_comb begin
      stop_strobe = strobe && (state == STOP);
      frm_bad     = stop_strobe && !dat_s;
      par_bad     = stop_strobe && dat_s && !ps2_odd_parity_ok(shreg, par_bit);
      frm_good    = stop_strobe && dat_s && ps2_odd_parity_ok(shreg, par_bit);
   end

   always_ff @(posedge clk) begin
      if (strobe && state == DATA)   shreg   <= {dat_s, shreg[PS2_DATA_BITS-1:1]};
      if (strobe && state == PARITY) par_bit <= dat_s;
      if (stop_strobe)               byte_p1 <= shreg;
   end

   // ---- stage 3: registered push and error pulses, one cycle after the stop strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         push_p1    <= 1'b0;
         par_err_p1 <= 1'b0;
         frm_err_p1 <= 1'b0;
         tmo_err_p1 <= 1'b0;
      end else begin
         push_p1    <= frm_good;
         par_err_p1 <= par_bad;
         frm_err_p1 <= frm_bad;
         tmo_err_p1 <= tmo_hit;
      end
   end

   ps2_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_p1),
      .push_data (byte_p1),
      .pop       (rx_ready),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign rx_valid    = !fifo_empty;
   assign rx_data     = rx_valid ? fifo_head : 8'h00;
   assign busy        = (state != IDLE);
   assign err_parity  = par_err_p1;
   assign err_frame   = frm_err_p1;
   assign err_timeout = tmo_err_p1;
   // Full implies non-empty, so rx_ready alone tells whether a slot frees this edge
   assign err_overrun = push_p1 && fifo_full && !rx_ready;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: drives PS/2 frames bit by bit and checks scancodes and
// error pulses against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

   localparam int SYNC_STAGES    = 2;
   localparam int FILTER_LEN     = 4;
   localparam int TIMEOUT_CYCLES = 600;
   localparam int FIFO_DEPTH     = 4;
   localparam int CW             = $clog2(FIFO_DEPTH + 1);
   localparam int H              = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ps2_clk = 1'b1;
   logic          ps2_data = 1'b1;
   logic          rx_ready = 1'b0;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [CW-1:0] fifo_count;
   logic          busy, err_parity, err_frame, err_timeout, err_overrun;

   int vectors = 0;
   int miscompares = 0;
   int n_par = 0, n_frm = 0, n_tmo = 0, n_ovr = 0;
   int e_par = 0, e_frm = 0, e_tmo = 0, e_ovr = 0;
   logic [7:0] exp_q[$];

   ps2_rx_fifo #(
      .SYNC_STAGES    (SYNC_STAGES),
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .FIFO_DEPTH     (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .fifo_count  (fifo_count),
      .busy        (busy),
      .err_parity  (err_parity),
      .err_frame   (err_frame),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   // Pulse counters: a one-cycle pulse counts exactly once
   always @(negedge clk) begin
      if (err_parity)  n_par <= n_par + 1;
      if (err_frame)   n_frm <= n_frm + 1;
      if (err_timeout) n_tmo <= n_tmo + 1;
      if (err_overrun) n_ovr <= n_ovr + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b, input int glitch);
      @(negedge clk);
      ps2_data = b;
      repeat (3) @(negedge clk);
      if (glitch > 0) begin
         ps2_clk = 1'b0;
         repeat (glitch) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (H - 3 - glitch) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // Reference behaviour of one complete frame at the receiver boundary
   task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      if (bad_stop)                      e_frm++;
      else if (bad_par)                  e_par++;
      else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
      else                               e_ovr++;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input bit glitchy);
      logic [10:0] bits;
      bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(bits[i], glitchy ? (i % 3) + 1 : 0);
      ps2_data = 1'b1;
      repeat (2 * H) @(negedge clk);
      model_frame(d, bad_par, bad_stop);
   endtask

   task automatic pop_one(output logic v, output logic [7:0] d);
      @(negedge clk);
      v = rx_valid;
      d = rx_data;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++;
      if ({rx_valid, rx_data, fifo_count, busy, err_parity, err_frame, err_timeout, err_overrun} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b data=%h count=%0d busy=%b errs=%b%b%b%b, want all 0",
                  rx_valid, rx_data, fifo_count, busy, err_parity, err_frame, err_timeout, err_overrun);
      end
      reset = 1'b1;
      repeat (20) @(negedge clk);
      vectors++;
      if ({n_par, n_frm, n_tmo, n_ovr, 31'd0, busy} !== {e_par, e_frm, e_tmo, e_ovr, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_release: busy=%b errs=%0d/%0d/%0d/%0d, want busy=0 no pulses",
                  busy, n_par, n_frm, n_tmo, n_ovr);
      end
   endtask

   task automatic test_single;
      logic v; logic [7:0] d;
      send_frame(8'h1C, 0, 0, 0);
      vectors++;
      if ({rx_valid, rx_data, fifo_count} !== {1'b1, 8'h1C, CW'(1)}) begin
         miscompares++;
         $display("FAIL single_head: valid=%b data=%h count=%0d, want 1 1c 1", rx_valid, rx_data, fifo_count);
      end
      vectors++;
      if ({n_par, n_frm, n_tmo, n_ovr} !== {e_par, e_frm, e_tmo, e_ovr}) begin
         miscompares++;
         $display("FAIL single_errs: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                  n_par, n_frm, n_tmo, n_ovr, e_par, e_frm, e_tmo, e_ovr);
      end
      pop_one(v, d);
      void'(exp_q.pop_front());
      @(negedge clk);
      vectors++;
      if ({rx_valid, rx_data, fifo_count} !== {1'b0, 8'h00, CW'(0)}) begin
         miscompares++;
         $display("FAIL single_popped: valid=%b data=%h count=%0d, want 0 00 0", rx_valid, rx_data, fifo_count);
      end
   endtask

   task automatic test_order_parity;
      logic v; logic [7:0] d; logic [7:0] want;
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h5A, 0, 0, 0);
      send_frame(8'h5A, 1, 0, 0);
      vectors++;
      if ({n_par, fifo_count} !== {e_par, CW'(exp_q.size())}) begin
         miscompares++;
         $display("FAIL parity_err: pulses=%0d count=%0d, want %0d %0d", n_par, fifo_count, e_par, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         pop_one(v, d);
         vectors++;
         if ({v, d} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL order_pop: valid=%b data=%h, want 1 %h", v, d, want);
         end
      end
   endtask

   task automatic test_frame_err;
      logic v; logic [7:0] d;
      send_frame(8'h3C, 0, 1, 0);
      send_frame(8'h77, 1, 1, 0);
      vectors++;
      if ({n_par, n_frm, 31'd0, rx_valid, 31'd0, busy} !== {e_par, e_frm, 64'd0}) begin
         miscompares++;
         $display("FAIL frame_err: par=%0d frm=%0d valid=%b busy=%b, want par=%0d frm=%0d valid=0 busy=0",
                  n_par, n_frm, rx_valid, busy, e_par, e_frm);
      end
      send_frame(8'h1C, 0, 0, 0);
      pop_one(v, d);
      vectors++;
      if ({v, d} !== {1'b1, exp_q.pop_front()}) begin
         miscompares++;
         $display("FAIL frame_recover: valid=%b data=%h, want 1 1c", v, d);
      end
   endtask

   task automatic test_timeout;
      logic v; logic [7:0] d;
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_busy: busy=%b, want 1", busy);
      end
      repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
      e_tmo++;
      vectors++;
      if ({n_tmo, 31'd0, busy, n_par, n_frm} !== {e_tmo, 32'd0, e_par, e_frm}) begin
         miscompares++;
         $display("FAIL timeout_pulse: tmo=%0d busy=%b par=%0d frm=%0d, want tmo=%0d busy=0 par=%0d frm=%0d",
                  n_tmo, busy, n_par, n_frm, e_tmo, e_par, e_frm);
      end
      send_frame(8'h29, 0, 0, 0);
      pop_one(v, d);
      vectors++;
      if ({v, d} !== {1'b1, exp_q.pop_front()}) begin
         miscompares++;
         $display("FAIL timeout_recover: valid=%b data=%h, want 1 29", v, d);
      end
   endtask

   task automatic test_overrun;
      logic v; logic [7:0] d; logic [7:0] want;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0);
      vectors++;
      if ({n_ovr, fifo_count} !== {e_ovr, CW'(4)}) begin
         miscompares++;
         $display("FAIL overrun_full: ovr=%0d count=%0d, want %0d 4", n_ovr, fifo_count, e_ovr);
      end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         pop_one(v, d);
         vectors++;
         if ({v, d} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL overrun_pop: valid=%b data=%h, want 1 %h", v, d, want);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic v; logic [7:0] d; logic [7:0] want; logic [9:0] bits; int k;
      bit seen;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 0, 0);
      bits = {~^8'h05, 8'h05, 1'b0};
      for (int i = 0; i < 10; i++) send_bit(bits[i], 0);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (H - 1) @(negedge clk);
      ps2_clk = 1'b0;
      seen = 0;
      // Pop exactly on the cycle the fifth byte is pushed (busy drops on that cycle)
      for (k = 0; k < 3 * H; k++) begin
         @(negedge clk);
         if (!busy) begin seen = 1; break; end
      end
      d = rx_data;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      vectors++;
      if ({seen, d} !== {1'b1, exp_q[0]}) begin
         miscompares++;
         $display("FAIL b2b_sync: busy_fell=%b popped=%h, want 1 %h", seen, d, exp_q[0]);
      end
      void'(exp_q.pop_front());
      exp_q.push_back(8'h05);
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (2 * H) @(negedge clk);
      vectors++;
      if ({n_ovr, fifo_count} !== {e_ovr, CW'(4)}) begin
         miscompares++;
         $display("FAIL b2b_accept: ovr=%0d count=%0d, want %0d 4", n_ovr, fifo_count, e_ovr);
      end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         pop_one(v, d);
         vectors++;
         if ({v, d} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL b2b_pop: valid=%b data=%h, want 1 %h", v, d, want);
         end
      end
   endtask

   task automatic test_glitch;
      logic v; logic [7:0] d; logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, 0, 0, 1);
      vectors++;
      if ({fifo_count, n_par, n_frm} !== {CW'(1), e_par, e_frm}) begin
         miscompares++;
         $display("FAIL glitch_count: count=%0d par=%0d frm=%0d, want 1 %0d %0d", fifo_count, n_par, n_frm, e_par, e_frm);
      end
      pop_one(v, d);
      vectors++;
      if ({v, d} !== {1'b1, exp_q.pop_front()}) begin
         miscompares++;
         $display("FAIL glitch_data: valid=%b data=%h, want 1 %h", v, d, b);
      end
   endtask

   task automatic test_random;
      logic v; logic [7:0] d; logic [7:0] want; int kind; int npop;
      for (int n = 0; n < 16; n++) begin
         kind = $urandom_range(0, 5);
         send_frame(8'($urandom), kind == 0 || kind == 2, kind == 1 || kind == 2, 0);
         vectors++;
         if ({fifo_count, n_par, n_frm, n_ovr} !== {CW'(exp_q.size()), e_par, e_frm, e_ovr}) begin
            miscompares++;
            $display("FAIL rand_state[%0d]: count=%0d par=%0d frm=%0d ovr=%0d, want %0d %0d %0d %0d",
                     n, fifo_count, n_par, n_frm, n_ovr, exp_q.size(), e_par, e_frm, e_ovr);
         end
         npop = $urandom_range(0, exp_q.size());
         for (int p = 0; p < npop; p++) begin
            want = exp_q.pop_front();
            pop_one(v, d);
            vectors++;
            if ({v, d} !== {1'b1, want}) begin
               miscompares++;
               $display("FAIL rand_pop[%0d]: valid=%b data=%h, want 1 %h", n, v, d, want);
            end
         end
      end
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         pop_one(v, d);
         vectors++;
         if ({v, d} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL rand_drain: valid=%b data=%h, want 1 %h", v, d, want);
         end
      end
      @(negedge clk);
      vectors++;
      if ({rx_valid, rx_data, fifo_count} !== '0) begin
         miscompares++;
         $display("FAIL rand_empty: valid=%b data=%h count=%0d, want 0 00 0", rx_valid, rx_data, fifo_count);
      end
   endtask

   task automatic test_reset_midframe;
      logic v; logic [7:0] d;
      send_frame(8'h33, 0, 0, 0);
      for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 0);
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      vectors++;
      if ({rx_valid, rx_data, fifo_count, busy, err_parity, err_frame, err_timeout, err_overrun} !== '0) begin
         miscompares++;
         $display("FAIL midreset_outputs: valid=%b data=%h count=%0d busy=%b errs=%b%b%b%b, want all 0",
                  rx_valid, rx_data, fifo_count, busy, err_parity, err_frame, err_timeout, err_overrun);
      end
      exp_q.delete();
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      vectors++;
      if ({n_par, n_frm, n_tmo, n_ovr, 31'd0, busy} !== {e_par, e_frm, e_tmo, e_ovr, 32'd0}) begin
         miscompares++;
         $display("FAIL midreset_release: busy=%b errs=%0d/%0d/%0d/%0d", busy, n_par, n_frm, n_tmo, n_ovr);
      end
      send_frame(8'h1C, 0, 0, 0);
      pop_one(v, d);
      vectors++;
      if ({v, d} !== {1'b1, exp_q.pop_front()}) begin
         miscompares++;
         $display("FAIL midreset_recover: valid=%b data=%h, want 1 1c", v, d);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_order_parity();
      test_frame_err();
      test_timeout();
      test_overrun();
      test_back_to_back();
      test_glitch();
      test_random();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
